// File: rtl/glm_write_arbiter.sv
// Round-robin arbiter sharing one DMA write channel among NUM_REQ writeback requesters.
// Optional perf counters (perf_lines, perf_stall) are enabled by defining GLM_WRITE_ARB_PERF_EN.
`timescale 1ns/1ps
module glm_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 42
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_len,
    input  logic [NUM_REQ-1:0]        req_fence,
    input  logic [NUM_REQ-1:0]        req_wvalid,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_almostfull,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    input  logic                      dma_idle,
    input  logic                      dma_active,
    input  logic                      dma_walmostfull,
    input  logic                      dma_wack,
    output logic                      dma_start,
    output logic [ADDR_W-1:0]         dma_addr,
    output logic [32:0]               dma_len,
    output logic                      dma_we,
    output logic [DATA_W-1:0]         dma_wdata
`ifdef GLM_WRITE_ARB_PERF_EN
    ,
    output logic [63:0]               perf_lines,
    output logic [63:0]               perf_stall
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_TRIGGER, S_STREAM, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, win, pick, cand;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        len_q, sent, acks;
    logic               fence_q;
    logic               accept, ack_en, finish;
    logic [NUM_REQ-1:0] af_nxt;

    // Search ptr+NUM_REQ down to ptr+1 so the nearest valid index after ptr wins.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand = IDX_W'((32'(ptr) + k) % 32'(NUM_REQ));
            if (req_valid[cand]) pick = cand;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = (state == S_STREAM) && req_wvalid[win] && dma_active && (sent != len_q);
        ack_en    = (state == S_STREAM) && dma_wack;
        finish    = fence_q ? (ack_en && (acks + 32'd1 == len_q))
                            : (accept && (sent + 32'd1 == len_q));
        af_nxt    = '1;
        if (state == S_STREAM) af_nxt[win] = dma_walmostfull || !dma_active;
        case (state)
            S_IDLE:    if (|req_valid) state_nxt = S_ARB;
            S_ARB:     state_nxt = (req_len[win*32 +: 32] == '0) ? S_DONE : S_TRIGGER;
            S_TRIGGER: if (dma_idle) state_nxt = S_STREAM;
            S_STREAM:  if (finish) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // The winner is registered on leaving IDLE so req_grant is already visible in ARB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr            <= IDX_W'(NUM_REQ - 1);
            win            <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            fence_q        <= 1'b0;
            sent           <= '0;
            acks           <= '0;
            req_almostfull <= '0;
            req_grant      <= '0;
            req_done       <= '0;
            dma_start      <= 1'b0;
            dma_addr       <= '0;
            dma_len        <= '0;
            dma_we         <= 1'b0;
            dma_wdata      <= '0;
        end else begin
            dma_start      <= 1'b0;
            dma_we         <= 1'b0;
            req_almostfull <= af_nxt;
            req_done       <= (state_nxt == S_DONE && state != S_DONE) ? req_grant : '0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        win       <= pick;
                        req_grant <= NUM_REQ'(1) << pick;
                    end
                end
                S_ARB: begin
                    ptr     <= win;
                    addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
                    len_q   <= req_len[win*32 +: 32];
                    fence_q <= req_fence[win];
                    sent    <= '0;
                    acks    <= '0;
                end
                S_TRIGGER: begin
                    if (dma_idle) begin
                        dma_start <= 1'b1;
                        dma_addr  <= addr_q;
                        dma_len   <= {1'b0, len_q};
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        dma_we    <= 1'b1;
                        dma_wdata <= req_wdata[win*DATA_W +: DATA_W];
                        sent      <= sent + 32'd1;
                    end
                    if (ack_en) acks <= acks + 32'd1;
                end
                S_DONE:  req_grant <= '0;
                default: req_grant <= '0;
            endcase
        end
    end

`ifdef GLM_WRITE_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_lines <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && (perf_lines != '1)) perf_lines <= perf_lines + 64'd1;
            if ((state == S_STREAM) && req_almostfull[win] && (perf_stall != '1))
                perf_stall <= perf_stall + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glm_write_arbiter.sv
// Directed, table-driven bench for glm_write_arbiter with two requesters and narrow data/address.
`timescale 1ns/1ps
module tb_glm_write_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*32-1:0] req_len = '0;
    logic [NR-1:0]   req_fence = '0;
    logic [NR-1:0]   req_wvalid = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   req_almostfull, req_grant, req_done;
    logic            dma_idle = 1'b1;
    logic            dma_active = 1'b1;
    logic            dma_walmostfull = 1'b0;
    logic            dma_wack = 1'b0;
    logic            dma_start, dma_we;
    logic [AW-1:0]   dma_addr;
    logic [32:0]     dma_len;
    logic [DW-1:0]   dma_wdata;

    int checks = 0;
    int failures = 0;
    int job_salt = 0;
    int done_order[$];
    logic [DW-1:0] exp_q[$];

    glm_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_fence(req_fence),
        .req_wvalid(req_wvalid), .req_wdata(req_wdata), .req_almostfull(req_almostfull),
        .req_grant(req_grant), .req_done(req_done),
        .dma_idle(dma_idle), .dma_active(dma_active), .dma_walmostfull(dma_walmostfull),
        .dma_wack(dma_wack), .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_we(dma_we), .dma_wdata(dma_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  wv;
        logic [31:0] wd;
        logic        idle;
        logic        wack;
        logic [1:0]  e_grant;
        logic [1:0]  e_done;
        logic        e_start;
        logic        e_we;
        logic [31:0] e_data;
        logic [1:0]  e_af;
    } vec_t;

    vec_t vec[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req_valid = '0;
        req_wvalid = '0;
        dma_wack = 1'b0;
        dma_walmostfull = 1'b0;
        dma_idle = 1'b1;
        repeat (n) tick();
    endtask

    // Requester/DMA model: requesters stream only when their almostfull is low;
    // a toggle pattern on dma_walmostfull exercises the registered backpressure path.
    task automatic serve(input logic [1:0] mask, input int l0, input int l1,
                         input bit toggle, input int first);
        int  lens[2];
        int  cnt[2];
        int  ndone = 0;
        int  nexp = 0;
        int  nwe = 0;
        bit  chk_af = 0;
        logic prev_f = 1'b0;
        lens[0] = l0;
        lens[1] = l1;
        cnt[0] = 0;
        cnt[1] = 0;
        job_salt++;
        done_order.delete();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'(32'h1000 * (i + 1));
            req_len[i*32 +: 32]  = lens[i];
            req_fence[i]         = 1'b0;
            if (mask[i]) nexp++;
        end
        req_valid = mask;
        for (int cyc = 0; cyc < 400 && ndone < nexp; cyc++) begin
            tick();
            if (dma_we) begin
                chk("serve_we_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) chk("serve_wdata", dma_wdata, exp_q.pop_front());
                nwe++;
            end
            for (int i = 0; i < NR; i++)
                if (!req_grant[i]) chk($sformatf("serve_af_nongrant%0d", i), req_almostfull[i], 1);
            if (chk_af) chk("serve_af_follow", req_almostfull[req_grant[1] ? 1 : 0], prev_f);
            if (dma_start) begin
                chk("serve_dma_addr", dma_addr, AW'(32'h1000 * ((req_grant[1] ? 1 : 0) + 1)));
                chk("serve_dma_len", dma_len, lens[req_grant[1] ? 1 : 0]);
                chk_af = 1;
            end
            for (int i = 0; i < NR; i++)
                if (req_done[i]) begin
                    done_order.push_back(i);
                    req_valid[i] = 1'b0;
                    ndone++;
                    chk_af = 0;
                end
            dma_walmostfull = toggle ? 1'(cyc >> 1) : 1'b0;
            prev_f = dma_walmostfull || !dma_active;
            for (int i = 0; i < NR; i++) begin
                if (req_grant[i] && !req_almostfull[i] && cnt[i] < lens[i]) begin
                    req_wvalid[i] = 1'b1;
                    req_wdata[i*DW +: DW] = 32'hA000_0000 + (job_salt << 12) + (i << 8) + cnt[i];
                    exp_q.push_back(req_wdata[i*DW +: DW]);
                    cnt[i]++;
                end else begin
                    req_wvalid[i] = 1'b0;
                end
            end
        end
        req_wvalid = '0;
        req_valid = '0;
        dma_walmostfull = 1'b0;
        chk("serve_jobs_done", ndone, nexp);
        chk("serve_we_count", nwe, (mask[0] ? l0 : 0) + (mask[1] ? l1 : 0));
        chk("serve_order_len", done_order.size(), nexp);
        if (done_order.size() >= 1) chk("serve_order_first", done_order[0], first);
        if (done_order.size() >= 2) chk("serve_order_second", done_order[1], 1 - first);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{2'b01, 2'b00, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11};
        vec[1]  = '{2'b01, 2'b00, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11};
        vec[2]  = '{2'b01, 2'b00, 32'h0,        1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11};
        vec[3]  = '{2'b01, 2'b00, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0,        2'b11};
        vec[4]  = '{2'b01, 2'b01, 32'hD000_0000, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'hD000_0000, 2'b10};
        vec[5]  = '{2'b01, 2'b01, 32'hD000_0001, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'hD000_0001, 2'b10};
        vec[6]  = '{2'b01, 2'b00, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b10};
        vec[7]  = '{2'b01, 2'b01, 32'hD000_0002, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'hD000_0002, 2'b10};
        vec[8]  = '{2'b01, 2'b01, 32'hD000_0003, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 32'hD000_0003, 2'b10};
        vec[9]  = '{2'b01, 2'b01, 32'hD000_0004, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11};
        vec[10] = '{2'b00, 2'b00, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", req_grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_af", req_almostfull, 0);
        chk("rst_start", dma_start, 0);
        chk("rst_we", dma_we, 0);
        chk("rst_len", dma_len, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);

        // Both requesters after reset: req0 then req1.
        serve(2'b11, 2, 3, 0, 0);
        idle_cycles(2);

        // Single job table: req0 addr 0x100, len 4, fence 0, with one dma_idle=0 stall.
        req_addr[0 +: AW] = 16'h0100;
        req_len[0 +: 32]  = 32'd4;
        req_fence[0]      = 1'b0;
        for (int r = 0; r < 11; r++) begin
            req_valid        = vec[r].valid;
            req_wvalid       = vec[r].wv;
            req_wdata[0 +: DW] = vec[r].wd;
            dma_idle         = vec[r].idle;
            dma_wack         = vec[r].wack;
            tick();
            chk($sformatf("v%0d_grant", r), req_grant, vec[r].e_grant);
            chk($sformatf("v%0d_done", r), req_done, vec[r].e_done);
            chk($sformatf("v%0d_start", r), dma_start, vec[r].e_start);
            chk($sformatf("v%0d_we", r), dma_we, vec[r].e_we);
            chk($sformatf("v%0d_af", r), req_almostfull, vec[r].e_af);
            if (vec[r].e_we) chk($sformatf("v%0d_wdata", r), dma_wdata, vec[r].e_data);
            if (vec[r].e_start) begin
                chk("v_dma_addr", dma_addr, 16'h0100);
                chk("v_dma_len", dma_len, 33'd4);
            end
        end
        idle_cycles(2);

        // Pointer now on req0: a simultaneous round starts with req1.
        serve(2'b11, 1, 2, 0, 1);
        idle_cycles(2);

        // Fence job: done follows the third ack, not the third send.
        req_addr[0 +: AW] = 16'h0200;
        req_len[0 +: 32]  = 32'd3;
        req_fence[0]      = 1'b1;
        req_valid = 2'b01;
        tick(); chk("f_grant", req_grant, 2'b01);
        tick();
        tick(); chk("f_start", dma_start, 1); chk("f_len", dma_len, 33'd3); chk("f_addr", dma_addr, 16'h0200);
        req_wvalid = 2'b01; req_wdata[0 +: DW] = 32'hF000_0000;
        tick(); chk("f_we0", dma_we, 1); chk("f_data0", dma_wdata, 32'hF000_0000);
        req_wdata[0 +: DW] = 32'hF000_0001; dma_wack = 1'b1;
        tick(); chk("f_we1", dma_we, 1); chk("f_done_a1", req_done, 0);
        req_wdata[0 +: DW] = 32'hF000_0002;
        tick(); chk("f_we2", dma_we, 1); chk("f_data2", dma_wdata, 32'hF000_0002); chk("f_done_a2", req_done, 0);
        req_wvalid = 2'b00; dma_wack = 1'b0;
        tick(); chk("f_done_wait", req_done, 0); chk("f_we_idle", dma_we, 0);
        req_wvalid = 2'b01; dma_wack = 1'b1;
        tick(); chk("f_done", req_done, 2'b01); chk("f_extra_we", dma_we, 0); chk("f_grant_done", req_grant, 2'b01);
        req_wvalid = 2'b00; req_valid = 2'b00;
        tick(); chk("f_done_end", req_done, 0); chk("f_grant_end", req_grant, 0);
        req_fence[0] = 1'b0;
        idle_cycles(2);

        // Zero-length job on req1: two grant cycles, done on the second, no DMA activity.
        req_len[32 +: 32] = 32'd0;
        req_valid = 2'b10;
        tick(); chk("z_grant0", req_grant, 2'b10); chk("z_done0", req_done, 0); chk("z_start0", dma_start, 0);
        tick(); chk("z_grant1", req_grant, 2'b10); chk("z_done1", req_done, 2'b10); chk("z_start1", dma_start, 0);
        req_valid = 2'b00;
        tick(); chk("z_grant2", req_grant, 0); chk("z_done2", req_done, 0); chk("z_we2", dma_we, 0);
        idle_cycles(2);

        // Length-8 job under toggling dma_walmostfull.
        serve(2'b01, 8, 0, 1, 0);
        idle_cycles(2);

        // Reset in the middle of streaming.
        req_addr[AW +: AW] = 16'h0300;
        req_len[32 +: 32]  = 32'd8;
        req_valid = 2'b10;
        begin
            int n = 0;
            while (!dma_start && n < 10) begin
                tick();
                n++;
            end
            chk("r_start_seen", dma_start, 1);
        end
        req_wvalid = 2'b10; req_wdata[DW +: DW] = 32'hBEEF_0001;
        tick();
        tick(); chk("r_we_before", dma_we, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("r_grant", req_grant, 0);
        chk("r_af", req_almostfull, 0);
        chk("r_we", dma_we, 0);
        chk("r_wdata", dma_wdata, 0);
        chk("r_addr", dma_addr, 0);
        chk("r_len", dma_len, 0);
        req_valid = '0;
        req_wvalid = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);
        chk("r_no_done", req_done, 0);
        serve(2'b11, 2, 3, 0, 0);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
